lsu_mem_stage: RTL and testbench

- Memory-access stage of the RV32I core, directly upstream of the data memory `dmem`.
- Accepts one load/store request from execute over a valid/ready handshake and checks alignment and funct3 legality.
- Drives the `dmem` port set for exactly one full clock cycle, then returns the load data or an error to writeback over a second valid/ready handshake.
- Also keeps load, store and error event counters.

---
 rtl/lsu_mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// RV32I memory-access stage: validates a load/store, drives dmem for one full cycle,
// then hands the load result or an access error to writeback. Also counts events.
module lsu_mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             req_we,
  input  logic             req_re,
  input  logic [2:0]       req_funct3,
  input  logic [4:0]       req_rd,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wr_data,
  output logic             dmem_mem_wr,
  output logic             dmem_mem_rd,
  output logic [2:0]       dmem_mask,
  input  logic [31:0]      dmem_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [4:0]       rsp_rd,
  output logic             rsp_we,
  output logic             rsp_err,
  output logic [31:0]      rsp_err_addr,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d;
  logic [31:0]      dmem_wr_data_q, dmem_wr_data_d;
  logic             dmem_mem_wr_q, dmem_mem_wr_d;
  logic             dmem_mem_rd_q, dmem_mem_rd_d;
  logic [2:0]       dmem_mask_q, dmem_mask_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_rd_q, rsp_rd_d;
  logic             rsp_we_q, rsp_we_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_err_addr_q, rsp_err_addr_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             illegal, misaligned;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    illegal = (req_we && req_re) || (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
              (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d        = state_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wr_data_d = dmem_wr_data_q;
    dmem_mem_wr_d  = dmem_mem_wr_q;
    dmem_mem_rd_d  = dmem_mem_rd_q;
    dmem_mask_d    = dmem_mask_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_rd_d       = rsp_rd_q;
    rsp_we_d       = rsp_we_q;
    rsp_err_d      = rsp_err_q;
    rsp_err_addr_d = rsp_err_addr_q;
    load_cnt_d     = load_cnt_q;
    store_cnt_d    = store_cnt_q;
    err_cnt_d      = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_rd_d       = req_rd;
          rsp_we_d       = 1'b0;
          rsp_data_d     = 32'h0;
          rsp_err_d      = 1'b0;
          rsp_err_addr_d = 32'h0;
          if (illegal || misaligned) begin
            rsp_err_d      = 1'b1;
            rsp_err_addr_d = req_addr;
            rsp_valid_d    = 1'b1;
            err_cnt_d      = sat_inc(err_cnt_q);
            state_d        = RESP;
          end else if (!req_we && !req_re) begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            // dmem port is registered so it is live for the entire ACCESS cycle
            dmem_addr_d    = req_addr;
            dmem_wr_data_d = req_wdata;
            dmem_mask_d    = req_funct3;
            dmem_mem_wr_d  = req_we;
            dmem_mem_rd_d  = req_re;
            state_d        = ACCESS;
          end
        end
      end
      ACCESS: begin
        rsp_data_d     = dmem_mem_rd_q ? dmem_rdata : 32'h0;
        rsp_we_d       = dmem_mem_rd_q && (rsp_rd_q != 5'd0);
        if (dmem_mem_rd_q) load_cnt_d  = sat_inc(load_cnt_q);
        else               store_cnt_d = sat_inc(store_cnt_q);
        dmem_addr_d    = 32'h0;
        dmem_wr_data_d = 32'h0;
        dmem_mask_d    = 3'b000;
        dmem_mem_wr_d  = 1'b0;
        dmem_mem_rd_d  = 1'b0;
        rsp_valid_d    = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      dmem_addr_q    <= 32'h0;
      dmem_wr_data_q <= 32'h0;
      dmem_mem_wr_q  <= 1'b0;
      dmem_mem_rd_q  <= 1'b0;
      dmem_mask_q    <= 3'b000;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 32'h0;
      rsp_rd_q       <= 5'd0;
      rsp_we_q       <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_err_addr_q <= 32'h0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wr_data_q <= dmem_wr_data_d;
      dmem_mem_wr_q  <= dmem_mem_wr_d;
      dmem_mem_rd_q  <= dmem_mem_rd_d;
      dmem_mask_q    <= dmem_mask_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_rd_q       <= rsp_rd_d;
      rsp_we_q       <= rsp_we_d;
      rsp_err_q      <= rsp_err_d;
      rsp_err_addr_q <= rsp_err_addr_d;
      load_cnt_q     <= load_cnt_d;
      store_cnt_q    <= store_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wr_data = dmem_wr_data_q;
  assign dmem_mem_wr  = dmem_mem_wr_q;
  assign dmem_mem_rd  = dmem_mem_rd_q;
  assign dmem_mask    = dmem_mask_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_rd       = rsp_rd_q;
  assign rsp_we       = rsp_we_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_err_addr = rsp_err_addr_q;
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a small behavioural dmem (combinational
// masked read, negedge write) and narrow counters to reach saturation quickly.
module tb_lsu_mem_stage;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we, req_re;
  logic [31:0]      req_addr, req_wdata;
  logic [2:0]       req_funct3;
  logic [4:0]       req_rd;
  logic [31:0]      dmem_addr, dmem_wr_data, dmem_rdata;
  logic             dmem_mem_wr, dmem_mem_rd;
  logic [2:0]       dmem_mask;
  logic             rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [31:0]      rsp_data, rsp_err_addr;
  logic [4:0]       rsp_rd;
  logic [CNT_W-1:0] load_cnt, store_cnt, err_cnt;

  logic [31:0] mem [0:63];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data), .dmem_mem_wr(dmem_mem_wr),
    .dmem_mem_rd(dmem_mem_rd), .dmem_mask(dmem_mask), .dmem_rdata(dmem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_err_addr(rsp_err_addr),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
  );

  // dmem: byte/half/word lanes selected by mask, sign-extended unless mask[2]
  always_comb begin
    logic [31:0] w, sh;
    w  = mem[dmem_addr[7:2]];
    sh = w >> {dmem_addr[1:0], 3'b000};
    case (dmem_mask)
      3'b000:  dmem_rdata = {{24{sh[7]}}, sh[7:0]};
      3'b001:  dmem_rdata = {{16{sh[15]}}, sh[15:0]};
      3'b100:  dmem_rdata = {24'h0, sh[7:0]};
      3'b101:  dmem_rdata = {16'h0, sh[15:0]};
      default: dmem_rdata = w;
    endcase
  end

  always @(negedge clk) begin
    if (dmem_mem_wr) begin
      case (dmem_mask[1:0])
        2'b00:   mem[dmem_addr[7:2]][{dmem_addr[1:0], 3'b000} +: 8]  <= dmem_wr_data[7:0];
        2'b01:   mem[dmem_addr[7:2]][{dmem_addr[1], 4'b0000} +: 16] <= dmem_wr_data[15:0];
        default: mem[dmem_addr[7:2]] <= dmem_wr_data;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // presents a request and returns just after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [2:0] f3, input logic [4:0] rd);
    req_valid = 1'b1; req_addr = a; req_wdata = wd;
    req_we = we; req_re = re; req_funct3 = f3; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_we = 1'b0; req_re = 1'b0; req_funct3 = '0; req_rd = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_dmem_wr", 32'(dmem_mem_wr), 32'h0);
    check("reset_load_cnt", 32'(load_cnt), 32'h0);

    // store word
    issue(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 3'b010, 5'd0);
    check("sw_mem_wr", 32'(dmem_mem_wr), 32'h1);
    check("sw_addr", dmem_addr, 32'h10);
    check("sw_wdata", dmem_wr_data, 32'hDEADBEEF);
    check("sw_mask", 32'(dmem_mask), 32'h2);
    check("sw_valid_early", 32'(rsp_valid), 32'h0);
    check("sw_req_ready", 32'(req_ready), 32'h0);
    step();
    check("sw_rsp_valid", 32'(rsp_valid), 32'h1);
    check("sw_rsp_we", 32'(rsp_we), 32'h0);
    check("sw_rsp_err", 32'(rsp_err), 32'h0);
    check("sw_store_cnt", 32'(store_cnt), 32'h1);
    check("sw_wr_dropped", 32'(dmem_mem_wr), 32'h0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    step();
    check("sw_back_idle", 32'(req_ready), 32'h1);
    check("sw_valid_clr", 32'(rsp_valid), 32'h0);

    // load word
    issue(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 5'd5);
    check("lw_mem_rd", 32'(dmem_mem_rd), 32'h1);
    check("lw_mem_wr", 32'(dmem_mem_wr), 32'h0);
    step();
    check("lw_data", rsp_data, 32'hDEADBEEF);
    check("lw_rd", 32'(rsp_rd), 32'h5);
    check("lw_we", 32'(rsp_we), 32'h1);
    check("lw_err_addr", rsp_err_addr, 32'h0);
    check("lw_load_cnt", 32'(load_cnt), 32'h1);
    step();

    // byte loads, signed and unsigned
    issue(32'h20, 32'h000080F0, 1'b1, 1'b0, 3'b010, 5'd0);
    step(); step();
    issue(32'h21, 32'h0, 1'b0, 1'b1, 3'b000, 5'd7);
    step();
    check("lb_data", rsp_data, 32'hFFFFFF80);
    step();
    issue(32'h21, 32'h0, 1'b0, 1'b1, 3'b100, 5'd7);
    step();
    check("lbu_data", rsp_data, 32'h00000080);
    step();

    issue(32'h0, 32'h11111111, 1'b1, 1'b0, 3'b010, 5'd0);
    step(); step();
    check("store_cnt3", 32'(store_cnt), 32'h3);

    // misaligned load word
    issue(32'h6, 32'h0, 1'b0, 1'b1, 3'b010, 5'd3);
    check("mis_valid", 32'(rsp_valid), 32'h1);
    check("mis_err", 32'(rsp_err), 32'h1);
    check("mis_err_addr", rsp_err_addr, 32'h6);
    check("mis_we", 32'(rsp_we), 32'h0);
    check("mis_data", rsp_data, 32'h0);
    check("mis_mem_rd", 32'(dmem_mem_rd), 32'h0);
    check("mis_err_cnt", 32'(err_cnt), 32'h1);
    step();

    // illegal store funct3=101
    issue(32'h30, 32'h12345678, 1'b1, 1'b0, 3'b101, 5'd0);
    check("ill_valid", 32'(rsp_valid), 32'h1);
    check("ill_err", 32'(rsp_err), 32'h1);
    check("ill_err_addr", rsp_err_addr, 32'h30);
    check("ill_mem_wr", 32'(dmem_mem_wr), 32'h0);
    check("ill_err_cnt", 32'(err_cnt), 32'h2);
    step();
    check("ill_no_store", 32'(store_cnt), 32'h3);

    // backpressure with rd=0 load
    rsp_ready = 1'b0;
    issue(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 5'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_data", rsp_data, 32'hDEADBEEF);
      check("bp_we", 32'(rsp_we), 32'h0);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      if (i == 2) begin
        req_valid = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
        req_we = 1'b1; req_re = 1'b0; req_funct3 = 3'b010;
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("bp_release_idle", 32'(req_ready), 32'h1);
    check("bp_release_valid", 32'(rsp_valid), 32'h0);
    check("bp_ignored_mem", mem[0], 32'h11111111);
    check("bp_ignored_cnt", 32'(store_cnt), 32'h3);

    // async reset during the high phase of ACCESS
    issue(32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 3'b010, 5'd0);
    check("rst_pre_wr", 32'(dmem_mem_wr), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_mem_wr", 32'(dmem_mem_wr), 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_store_cnt", 32'(store_cnt), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    #1;
    check("rst_mem_kept", mem[0], 32'h11111111);
    step();
    rst = 1'b0;
    step();
    check("rst_idle", 32'(req_ready), 32'h1);
    check("rst_load_cnt", 32'(load_cnt), 32'h0);

    // counter saturation
    for (int i = 0; i < 5; i++) begin
      issue(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 5'd1);
      step(); step();
      if (i == 1) check("sat_load_cnt2", 32'(load_cnt), 32'h2);
    end
    check("sat_load_cnt", 32'(load_cnt), 32'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
